load_mem_responder: RTL and testbench

//  Memory-side responder for the tagged load request/response protocol driven by the load queue.

---
 rtl/load_mem_responder.sv | 144 ++++++++++++++
 tb/tb_load_mem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_mem_responder.sv
// Memory-side responder for tagged load requests: SLOTS in-flight slots, address-selected
// latency, out-of-order tagged responses from a word-organised memory with a preload port.
module load_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 3,
  parameter int SLOTS      = 4,
  parameter int MEM_WORDS  = 1024,
  parameter int FAST_LAT   = 2,
  parameter int SLOW_LAT   = 6,
  parameter int LAT_BIT    = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  input  logic [TAG_WIDTH-1:0]       req_tag,
  output logic                       req_ready,
  output logic                       resp_valid,
  output logic [DATA_WIDTH-1:0]      resp_data,
  output logic [TAG_WIDTH-1:0]       resp_tag,
  input  logic                       wr_en,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic [$clog2(SLOTS+1)-1:0] inflight
);

  localparam int IDX_W   = $clog2(MEM_WORDS);
  localparam int MAX_LAT = (FAST_LAT > SLOW_LAT) ? FAST_LAT : SLOW_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam int SW      = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int INF_W   = $clog2(SLOTS + 1);
  localparam logic [CNT_W-1:0] FAST_CNT = CNT_W'(FAST_LAT - 1);
  localparam logic [CNT_W-1:0] SLOW_CNT = CNT_W'(SLOW_LAT - 1);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [SLOTS-1:0]      valid_q, valid_d;
  logic [CNT_W-1:0]      cnt_q   [SLOTS];
  logic [CNT_W-1:0]      cnt_d   [SLOTS];
  logic [TAG_WIDTH-1:0]  tag_q   [SLOTS];
  logic [TAG_WIDTH-1:0]  tag_d   [SLOTS];
  logic [1:0]            off_q   [SLOTS];
  logic [1:0]            off_d   [SLOTS];
  logic [DATA_WIDTH-1:0] word_q  [SLOTS];
  logic [DATA_WIDTH-1:0] word_d  [SLOTS];

  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [TAG_WIDTH-1:0]  resp_tag_q, resp_tag_d;

  logic          acc_hit, done_hit;
  logic [SW-1:0] acc_sel, done_sel;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{req_addr, wr_addr};

  always_comb begin
    acc_hit  = 1'b0;
    acc_sel  = '0;
    done_hit = 1'b0;
    done_sel = '0;
    // Descending scan so the lowest index wins for both free and done slots.
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        acc_hit = 1'b1;
        acc_sel = SW'(i);
      end
      if (valid_q[i] && (cnt_q[i] == '0)) begin
        done_hit = 1'b1;
        done_sel = SW'(i);
      end
    end
  end

  assign req_ready = acc_hit;

  always_comb begin
    valid_d      = valid_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_tag_d   = resp_tag_q;
    for (int i = 0; i < SLOTS; i++) begin
      cnt_d[i]  = cnt_q[i];
      tag_d[i]  = tag_q[i];
      off_d[i]  = off_q[i];
      word_d[i] = word_q[i];
      if (valid_q[i] && (cnt_q[i] != '0)) cnt_d[i] = cnt_q[i] - 1'b1;
    end
    if (done_hit) begin
      valid_d[done_sel] = 1'b0;
      resp_valid_d      = 1'b1;
      resp_data_d       = word_q[done_sel] >> {off_q[done_sel], 3'b000};
      resp_tag_d        = tag_q[done_sel];
    end
    // The accepted slot was free before this edge, so it never collides with the done slot.
    if (req_valid && acc_hit) begin
      valid_d[acc_sel] = 1'b1;
      cnt_d[acc_sel]   = req_addr[LAT_BIT] ? SLOW_CNT : FAST_CNT;
      tag_d[acc_sel]   = req_tag;
      off_d[acc_sel]   = req_addr[1:0];
      word_d[acc_sel]  = mem[req_addr[2 +: IDX_W]];
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < SLOTS; i++) inflight = inflight + INF_W'(valid_q[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
      for (int i = 0; i < SLOTS; i++) cnt_q[i] <= '0;
    end else begin
      valid_q      <= valid_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
      for (int i = 0; i < SLOTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Slot payload is qualified by valid_q and needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SLOTS; i++) begin
      tag_q[i]  <= tag_d[i];
      off_q[i]  <= off_d[i];
      word_q[i] <= word_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[2 +: IDX_W]] <= wr_data;
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_tag   = resp_tag_q;

endmodule

// File: tb/tb_load_mem_responder.sv
// Directed and randomized bench for load_mem_responder against a slot/ready-time reference model.
module tb_load_mem_responder;

  localparam int SLOTS = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_tag;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [2:0]  resp_tag;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  inflight;

  load_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_tag(req_tag), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total  = 0;
  int n_passed = 0;

  // Reference model: each occupied slot holds its tag, pre-shifted data and the edge at which it may return.
  logic [31:0] mmem [1024];
  logic        m_valid [SLOTS];
  logic [2:0]  m_tag   [SLOTS];
  logic [31:0] m_data  [SLOTS];
  int          m_rdy   [SLOTS];
  logic        exp_rv;
  logic [31:0] exp_data;
  logic [2:0]  exp_tag;
  int          edge_n;
  logic        last_acc;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < SLOTS; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  task automatic cycle(input logic v, input logic [31:0] a, input logic [2:0] t,
                       input logic we, input logic [31:0] wa, input logic [31:0] wd);
    int fs;
    int ds;
    logic [31:0] w;
    req_valid = v; req_addr = a; req_tag = t;
    wr_en = we; wr_addr = wa; wr_data = wd;
    #2;
    fs = -1;
    ds = -1;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!m_valid[i]) fs = i;
      if (m_valid[i] && m_rdy[i] <= edge_n) ds = i;
    end
    chk("req_ready", 32'(req_ready), 32'(fs >= 0));
    exp_rv = 1'b0;
    if (ds >= 0) begin
      exp_rv     = 1'b1;
      exp_data   = m_data[ds];
      exp_tag    = m_tag[ds];
      m_valid[ds] = 1'b0;
    end
    last_acc = v && (fs >= 0);
    if (last_acc) begin
      w           = mmem[a[11:2]];
      m_valid[fs] = 1'b1;
      m_tag[fs]   = t;
      m_data[fs]  = w >> (8 * a[1:0]);
      m_rdy[fs]   = edge_n + (a[12] ? 6 : 2);
    end
    if (we) mmem[wa[11:2]] = wd;
    @(posedge clk);
    edge_n++;
    #1;
    chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
    chk("resp_data", resp_data, exp_data);
    chk("resp_tag", 32'(resp_tag), 32'(exp_tag));
    chk("inflight", 32'(inflight), 32'(model_count()));
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (model_count() == 0) break;
      idle();
    end
    chk("drain_inflight", 32'(inflight), 32'd0);
  endtask

  initial begin
    int waited;
    edge_n = 0;
    exp_data = 32'h0;
    exp_tag  = 3'd0;
    for (int i = 0; i < SLOTS; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 3'd0; m_data[i] = 32'h0; m_rdy[i] = 0;
    end
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = 32'h0; req_tag = 3'd0;
    wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_tag", 32'(resp_tag), 32'd0);
    #21 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 1024; i++) cycle(1'b0, 32'h0, 3'd0, 1'b1, 32'(i * 4), $urandom);

    // Basic fast request
    cycle(1'b0, 32'h0, 3'd0, 1'b1, 32'h10, 32'hA1B2C3D4);
    cycle(1'b1, 32'h10, 3'd5, 1'b0, 32'h0, 32'h0);
    idle();
    chk("t1_early", 32'(resp_valid), 32'd0);
    idle();
    chk("t1_valid", 32'(resp_valid), 32'd1);
    chk("t1_data", resp_data, 32'hA1B2C3D4);
    chk("t1_tag", 32'(resp_tag), 32'd5);
    drain();

    // Slow then fast: out-of-order return
    cycle(1'b1, 32'h1010, 3'd1, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'h0010, 3'd2, 1'b0, 32'h0, 32'h0);
    idle();
    idle();
    chk("t2_fast_valid", 32'(resp_valid), 32'd1);
    chk("t2_fast_tag", 32'(resp_tag), 32'd2);
    idle();
    idle();
    idle();
    chk("t2_slow_valid", 32'(resp_valid), 32'd1);
    chk("t2_slow_tag", 32'(resp_tag), 32'd1);
    drain();

    // Fill all slots, then hold a fifth request
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h1000 + 32'(4 * i), 3'(i), 1'b0, 32'h0, 32'h0);
    chk("t3_inflight", 32'(inflight), 32'd4);
    chk("t3_ready", 32'(req_ready), 32'd0);
    waited = -1;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 32'h10, 3'd4, 1'b0, 32'h0, 32'h0);
      if (last_acc) begin
        waited = k;
        break;
      end
    end
    chk("t3_wait", 32'(waited), 32'd3);
    drain();

    // Byte offsets
    cycle(1'b1, 32'h11, 3'd0, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'h12, 3'd1, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'h13, 3'd2, 1'b0, 32'h0, 32'h0);
    chk("t4_off1", resp_data, 32'h00A1B2C3);
    idle();
    chk("t4_off2", resp_data, 32'h0000A1B2);
    idle();
    chk("t4_off3", resp_data, 32'h000000A1);
    drain();

    // Two slots done on the same edge
    cycle(1'b1, 32'h1010, 3'd6, 1'b0, 32'h0, 32'h0);
    idle();
    idle();
    idle();
    cycle(1'b1, 32'h14, 3'd7, 1'b0, 32'h0, 32'h0);
    idle();
    idle();
    chk("t5_first_valid", 32'(resp_valid), 32'd1);
    chk("t5_first_tag", 32'(resp_tag), 32'd6);
    idle();
    chk("t5_second_valid", 32'(resp_valid), 32'd1);
    chk("t5_second_tag", 32'(resp_tag), 32'd7);
    drain();

    // Same-edge write returns the old word
    cycle(1'b1, 32'h10, 3'd3, 1'b1, 32'h10, 32'h55667788);
    idle();
    idle();
    chk("rbw_data", resp_data, 32'hA1B2C3D4);
    drain();

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 9) < 6, $urandom, 3'($urandom), $urandom_range(0, 9) == 0, $urandom, $urandom);
    drain();

    // Reset with requests in flight
    cycle(1'b0, 32'h0, 3'd0, 1'b1, 32'h10, 32'hA1B2C3D4);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h1020 + 32'(4 * i), 3'(i), 1'b0, 32'h0, 32'h0);
    chk("t6_pre_inflight", 32'(inflight), 32'd3);
    req_valid = 1'b0;
    wr_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_resp_valid", 32'(resp_valid), 32'd0);
    chk("t6_inflight", 32'(inflight), 32'd0);
    chk("t6_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < SLOTS; i++) m_valid[i] = 1'b0;
    exp_data = 32'h0;
    exp_tag  = 3'd0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    edge_n += 3;
    for (int i = 0; i < 8; i++) idle();
    cycle(1'b1, 32'h10, 3'd3, 1'b0, 32'h0, 32'h0);
    idle();
    idle();
    chk("t6_mem_valid", 32'(resp_valid), 32'd1);
    chk("t6_mem_data", resp_data, 32'hA1B2C3D4);
    drain();

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
